skid_pipe_register: RTL and testbench

//  - Posedge-clocked, two-entry registered skid buffer with valid/ready handshake on both sides.
//  - Consumer end of the negedge load-register path: captures words launched on the falling

---
 rtl/skid_pipe_register.sv | 114 +++++++++++
 tb/tb_skid_pipe_register.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/skid_pipe_register.sv
// Two-entry registered skid buffer; all outputs come straight from flops.
// Optional macro SKID_PIPE_STATS_EN adds a saturating stall counter output.
module skid_pipe_register #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
`ifdef SKID_PIPE_STATS_EN
  ,
  output logic [15:0]  stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_r;
  state_t       next_state_s;
  logic [N-1:0] main_r;
  logic [N-1:0] skid_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         in_xfer_s;
  logic         out_xfer_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (in_xfer_s) next_state_s = BUSY;
        else           next_state_s = EMPTY;
      end
      BUSY: begin
        if (in_xfer_s && !out_xfer_s)      next_state_s = FULL;
        else if (!in_xfer_s && out_xfer_s) next_state_s = EMPTY;
        else                               next_state_s = BUSY;
      end
      FULL: begin
        if (out_xfer_s) next_state_s = BUSY;
        else            next_state_s = FULL;
      end
      default: next_state_s = EMPTY;
    endcase
  end

  // Flush only clears occupancy; stored words go stale but are never presented again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= EMPTY;
      main_r      <= {N{1'b0}};
      skid_r      <= {N{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else if (flush) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s != EMPTY);
      in_ready_r  <= (next_state_s != FULL);
      case (state_r)
        EMPTY: begin
          if (in_xfer_s) main_r <= in_data;
        end
        BUSY: begin
          if (in_xfer_s && out_xfer_s) main_r <= in_data;
          else if (in_xfer_s)          skid_r <= in_data;
        end
        FULL: begin
          if (out_xfer_s) main_r <= skid_r;
        end
        default: begin
          main_r <= main_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

`ifdef SKID_PIPE_STATS_EN
  logic [15:0] stall_count_r;

  // Saturating count of stalled cycles; deliberately untouched by flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count_r <= 16'd0;
    end else if (out_valid_r && !out_ready && (stall_count_r != 16'hFFFF)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_skid_pipe_register.sv
// Directed self-checking bench for skid_pipe_register, plus a short queue-model stress run.
module tb_skid_pipe_register;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef SKID_PIPE_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  skid_pipe_register #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SKID_PIPE_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] q[$];
  logic        exp_ready;
  logic        in_x;
  logic        out_x;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;

    // Reset
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming 1..4
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_data", out_data, 32'(i));
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", {31'd0, out_valid}, 32'd0);

    // Back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_00A5;
    tick();
    check("bp_busy_data", out_data, 32'h0000_00A5);
    check("bp_busy_ready", {31'd0, in_ready}, 32'd1);
    in_data = 32'h0000_005A;
    tick();
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_data", out_data, 32'h0000_00A5);
    check("bp_full_valid", {31'd0, out_valid}, 32'd1);
    in_data = 32'h0000_00FF;
    tick();
    check("bp_hold_data", out_data, 32'h0000_00A5);
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_drain1_data", out_data, 32'h0000_005A);
    check("bp_drain1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_drain2_valid", {31'd0, out_valid}, 32'd0);

    // Flush while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    check("fl_full_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_data = 32'h33;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_full_valid", {31'd0, out_valid}, 32'd0);
    check("fl_full_ready2", {31'd0, in_ready}, 32'd1);

    // Flush while BUSY with an accepted same-cycle word
    in_valid = 1'b1; in_data = 32'h44;
    tick();
    flush = 1'b1; in_data = 32'h55;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_busy_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("fl_busy_stay_empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_data = 32'h66;
    tick();
    check("fl_next_word", out_data, 32'h66);
    in_valid = 1'b0;
    tick();

    // X on in_data without a transfer must not reach the output
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_valid = 1'b0; in_data = 'x;
    tick();
    check("x_block_data", out_data, 32'h77);
    check("x_block_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; in_data = 32'd0;
    tick();
    check("x_drain", {31'd0, out_valid}, 32'd0);

    // Random valid/ready against a reference queue
    exp_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      in_data   = $urandom();
      in_x  = in_valid && exp_ready;
      out_x = (q.size() > 0) && out_ready;
      tick();
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(in_data);
      exp_ready = (q.size() < 2);
      check("rnd_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      check("rnd_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      if (q.size() > 0) check("rnd_data", out_data, q[0]);
    end

    // Reset mid-transfer while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88;
    tick(); tick(); tick();
    rst = 1'b0; in_data = 32'h99;
    tick();
    check("rmid_valid", {31'd0, out_valid}, 32'd0);
    check("rmid_data", out_data, 32'd0);
    check("rmid_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("rmid_rel_ready", {31'd0, in_ready}, 32'd1);

`ifdef SKID_PIPE_STATS_EN
    in_valid = 1'b1; in_data = 32'hAB;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 70000; k++) tick();
    check("stat_sat", {16'd0, stall_count}, 32'h0000_FFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stat_flush", {16'd0, stall_count}, 32'h0000_FFFF);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("stat_rst", {16'd0, stall_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
